fifo_wr_ctrl: RTL and testbench

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/fifo_wr_ctrl.sv | 83 ++++++++
 tb/tb_fifo_wr_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary conversion and the default address width.
// Both conversions work on 32-bit values; callers zero-extend and then truncate to their own width.
package fifo_pkg;

  localparam int AWIDTH_DEF = 9;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i + 1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: pointer, full/overflow flags, optional occupancy.
// Define FIFO_WR_LEVEL_EN to build the wlevel / walmost_full logic; otherwise both are tied to 0.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int AWIDTH    = AWIDTH_DEF,
  parameter int AF_THRESH = 2**AWIDTH - 4
) (
  input  logic              wclk,
  input  logic              arst_n,
  input  logic              wreq,
  output logic              wen,
  output logic [AWIDTH-1:0] waddr,
  output logic [AWIDTH:0]   wptr_gray,
  input  logic [AWIDTH:0]   rptr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [AWIDTH:0]   wlevel,
  output logic              wovf,
  input  logic              ovf_clr
);

  localparam int PW = AWIDTH + 1;

  logic [AWIDTH:0] wbin;
  logic [AWIDTH:0] wbin_next;
  logic [AWIDTH:0] wgray_next;
  logic [AWIDTH:0] rsync;
  logic [AWIDTH:0] rsync_full;

  sync_2ff #(.WIDTH(PW)) u_rptr_sync (
    .clk    (wclk),
    .arst_n (arst_n),
    .d      (rptr_gray),
    .q      (rsync)
  );

  // Gating with arst_n keeps the RAM write port quiet while reset is held.
  assign wen        = wreq & ~wfull & arst_n;
  assign waddr      = wbin[AWIDTH-1:0];
  assign wbin_next  = wbin + {{AWIDTH{1'b0}}, wen};
  assign wgray_next = PW'(bin2gray(32'(wbin_next)));
  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign rsync_full = {~rsync[AWIDTH:AWIDTH-1], rsync[AWIDTH-2:0]};

  always_ff @(posedge wclk or negedge arst_n) begin
    if (!arst_n) begin
      wbin      <= '0;
      wptr_gray <= '0;
      wfull     <= 1'b0;
      wovf      <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
      wfull     <= (wgray_next == rsync_full);
      wovf      <= (wreq & wfull) | (wovf & ~ovf_clr);
    end
  end

`ifdef FIFO_WR_LEVEL_EN
  localparam logic [31:0] AF_U = 32'(AF_THRESH);

  logic [AWIDTH:0] rbin;
  logic [AWIDTH:0] level_next;

  assign rbin       = PW'(gray2bin(32'(rsync)));
  assign level_next = wbin_next - rbin;

  always_ff @(posedge wclk or negedge arst_n) begin
    if (!arst_n) begin
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= level_next;
      walmost_full <= (32'(level_next) >= AF_U);
    end
  end
`else
  assign wlevel       = '0;
  assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl (AWIDTH=3, AF_THRESH=6) with a write-address scoreboard.
module tb_fifo_wr_ctrl;

  localparam int AW    = 3;
  localparam int AF    = 6;
  localparam int DEPTH = 2**AW;

  logic          wclk = 1'b0;
  logic          arst_n;
  logic          wreq;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          wovf;
  logic          ovf_clr;

  fifo_wr_ctrl #(.AWIDTH(AW), .AF_THRESH(AF)) dut (
    .wclk         (wclk),
    .arst_n       (arst_n),
    .wreq         (wreq),
    .wen          (wen),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .rptr_gray    (rptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf),
    .ovf_clr      (ovf_clr)
  );

  always #5 wclk = ~wclk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW-1:0] sb_q[$];

  // Reference model: binary pointers, read pointer delayed by two edges.
  logic [AW:0] m_bin, rd_bin, rs1, rs2, m_lvl;
  logic        m_full, m_ovf;

  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_regs();
    check_val("wfull", 32'(wfull), 32'(m_full));
    check_val("wovf", 32'(wovf), 32'(m_ovf));
    check_val("waddr_reg", 32'(waddr), 32'(m_bin[AW-1:0]));
    check_val("wptr_gray", 32'(wptr_gray), 32'(to_gray(m_bin)));
`ifdef FIFO_WR_LEVEL_EN
    check_val("wlevel", 32'(wlevel), 32'(m_lvl));
    check_val("walmost_full", 32'(walmost_full), 32'(m_lvl >= AW'(0) + (AW+1)'(AF)));
`else
    check_val("wlevel", 32'(wlevel), 32'd0);
    check_val("walmost_full", 32'(walmost_full), 32'd0);
`endif
  endtask

  task automatic cyc(input logic req, input logic clr);
    logic        acc;
    logic [AW:0] nxt, rd_drv, prev_g;
    @(negedge wclk);
    wreq      = req;
    ovf_clr   = clr;
    rd_drv    = rd_bin;
    rptr_gray = to_gray(rd_drv);
    acc       = req && !m_full;
    if (acc) sb_q.push_back(m_bin[AW-1:0]);
    #2;
    check_val("wen", 32'(wen), 32'(acc));
    if (wen && sb_q.size() != 0) check_val("waddr", 32'(waddr), 32'(sb_q.pop_front()));
    prev_g = wptr_gray;
    nxt    = m_bin + (AW+1)'(acc);
    @(posedge wclk);
    #1;
    m_ovf  = (req && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_bin  = nxt;
    m_lvl  = nxt - rs2;
    m_full = (32'(m_lvl) == DEPTH);
    rs2    = rs1;
    rs1    = rd_drv;
    check_regs();
    if (acc) check_val("gray_1bit", 32'($countones(prev_g ^ wptr_gray)), 32'd1);
  endtask

  task automatic model_reset();
    m_bin = '0; rd_bin = '0; rs1 = '0; rs2 = '0; m_lvl = '0;
    m_full = 1'b0; m_ovf = 1'b0;
    sb_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_wen"}, 32'(wen), 32'd0);
    check_val({tag, "_waddr"}, 32'(waddr), 32'd0);
    check_val({tag, "_wptr_gray"}, 32'(wptr_gray), 32'd0);
    check_val({tag, "_wfull"}, 32'(wfull), 32'd0);
    check_val({tag, "_walmost_full"}, 32'(walmost_full), 32'd0);
    check_val({tag, "_wlevel"}, 32'(wlevel), 32'd0);
    check_val({tag, "_wovf"}, 32'(wovf), 32'd0);
  endtask

  initial begin
    arst_n    = 1'b0;
    wreq      = 1'b1;
    ovf_clr   = 1'b0;
    rptr_gray = '0;
    model_reset();
    @(posedge wclk);
    #1;
    check_reset_outputs("rst");

    @(negedge wclk);
    arst_n = 1'b1;
    wreq   = 1'b0;

    // Fill all eight slots with the read pointer parked at 0.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0);
    check_val("full_after_fill", 32'(wfull), 32'd1);

    // Rejected write, clear, then set and clear together.
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);

    // Reader consumes two entries; full must drop within three edges.
    rd_bin = (AW+1)'(2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    check_val("full_released", 32'(wfull), 32'd0);

    // Reader catches up, then 20 writes with the reader tracking across the wrap.
    rd_bin = m_bin;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0);
      rd_bin = m_bin;
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);

    // Build occupancy 5, then reset mid-operation.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0);
    @(negedge wclk);
    #1;
    arst_n    = 1'b0;
    wreq      = 1'b1;
    rptr_gray = '0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge wclk);
    #1;
    arst_n = 1'b1;
    wreq   = 1'b0;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
